// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry path: FSM encoding, the key layout
// and small helpers for decoding active-low row patterns.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Phone-style layout: rows top to bottom, columns left to right.
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0:    k = 4'h1;
            4'h1:    k = 4'h2;
            4'h2:    k = 4'h3;
            4'h3:    k = 4'hA;
            4'h4:    k = 4'h4;
            4'h5:    k = 4'h5;
            4'h6:    k = 4'h6;
            4'h7:    k = 4'hB;
            4'h8:    k = 4'h7;
            4'h9:    k = 4'h8;
            4'hA:    k = 4'h9;
            4'hB:    k = 4'hC;
            4'hC:    k = 4'hE;
            4'hD:    k = 4'h0;
            4'hE:    k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    function automatic logic one_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV clocks;
// the tick paces column dwell and every debounce decision.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_entry_controller.sv
// 4x4 hex keypad scanner with press/release debounce, key decode and a
// 16-bit shift-in entry register (newest nibble in [3:0]).
module keypad_entry_controller #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] entry
);
    import keypad_pkg::*;

    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] DB_ONE  = DW'(1);

    logic          tick;
    logic [3:0]    row_p0, row_s;
    state_t        state_q, state_d;
    logic [1:0]    col_sel_q, col_sel_d;
    logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cand_row_q, cand_row_d;
    logic [1:0]    cand_col_q, cand_col_d;
    logic [3:0]    acc_row;
    logic [1:0]    acc_col;
    logic [3:0]    acc_code;
    logic          accept;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // p0/s: two-flop synchronizer for the asynchronous row pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_p0 <= 4'hF;
            row_s  <= 4'hF;
        end else begin
            row_p0 <= row;
            row_s  <= row_p0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SCAN;
            col_sel_q <= 2'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_sel_q <= col_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        cand_row_q <= cand_row_d;
        cand_col_q <= cand_col_d;
    end

    always_comb begin
        state_d    = state_q;
        col_sel_d  = col_sel_q;
        cnt_d      = cnt_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        cnt_inc    = cnt_q + 1'b1;
        acc_row    = cand_row_q;
        acc_col    = cand_col_q;
        accept     = 1'b0;
        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (one_low(row_s)) begin
                        cand_row_d = row_s;
                        cand_col_d = col_sel_q;
                        acc_row    = row_s;
                        acc_col    = col_sel_q;
                        // A single agreeing tick is enough when debounce depth is one
                        if (DB_ONE == DB_LAST) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d   = DB_ONE;
                            state_d = PRESS_DB;
                        end
                    end else begin
                        col_sel_d = col_sel_q + 1'b1;
                    end
                end
            end
            PRESS_DB: begin
                if (tick) begin
                    if (row_s == cand_row_q) begin
                        if (cnt_inc == DB_LAST) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end
            end
            HELD: begin
                if (tick) begin
                    if (row_s == 4'hF) begin
                        if (cnt_inc == DB_LAST) begin
                            cnt_d   = '0;
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
        endcase
    end

    assign acc_code = keymap(low_index(acc_row), acc_col);
    assign col      = ~(4'b0001 << col_sel_q);

    // Clear has priority over a same-cycle key so the operator's clear always sticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            entry     <= 16'h0000;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= acc_code;
            end
            if (clr) begin
                entry <= 16'h0000;
            end else if (accept) begin
                entry <= {entry[11:0], acc_code};
            end
        end
    end

endmodule
